// File: rtl/test.sv
// test: free-running UART-style frame generator sending an incrementing 8-bit payload.
// Optional even-parity bit after the data bits is enabled by defining TEST_PARITY_EN.
module test #(
  parameter int CLKS_PER_BIT = 4,
  parameter int GAP_BITS = 2
) (
  input  logic clk,
  input  logic rst,
  output logic out
);
`ifdef TEST_PARITY_EN
  typedef enum logic [2:0] {GAP, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {GAP, START, DATA, STOP} state_t;
`endif
  state_t state, nxt;
  logic [15:0] cnt;
  logic [3:0] bit_idx, nbits;
  logic [7:0] payload;
  logic bit_v, bit_end, last;
  // state/counters describe the cycle about to be driven onto out at the next edge
  always_comb begin
    nbits = state == GAP ? 4'(GAP_BITS) : state == DATA ? 4'd8 : 4'd1;
    bit_v = state == START ? 1'b0 : state == DATA ? payload[bit_idx[2:0]] : 1'b1;
`ifdef TEST_PARITY_EN
    if (state == PARITY) bit_v = ^payload;
    nxt = state == GAP ? START : state == START ? DATA : state == DATA ? PARITY : state == PARITY ? STOP : GAP;
`else
    nxt = state == GAP ? START : state == START ? DATA : state == DATA ? STOP : GAP;
`endif
    bit_end = cnt == 16'(CLKS_PER_BIT - 1);
    last = bit_end && bit_idx == nbits - 4'd1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      out <= 1'b1;
      state <= GAP;
      cnt <= '0;
      bit_idx <= '0;
      payload <= '0;
    end else begin
      out <= bit_v;
      cnt <= bit_end ? 16'd0 : cnt + 16'd1;
      bit_idx <= last ? 4'd0 : bit_end ? bit_idx + 4'd1 : bit_idx;
      if (last) state <= nxt;
      if (last && state == STOP) payload <= payload + 8'd1;
    end
  end
endmodule

// File: tb/tb_test.sv
// tb_test: table vectors, frame decoding and a per-cycle arithmetic frame model for two configurations.
module tb_test;
  logic clk = 1'b0, rst = 1'b1, out4, out1;
`ifdef TEST_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int L4 = (2 + 10 + P) * 4;
  test dut (.clk(clk), .rst(rst), .out(out4));
  test #(.CLKS_PER_BIT(1), .GAP_BITS(1)) dut1 (.clk(clk), .rst(rst), .out(out1));
  always #5 clk = ~clk;

  typedef struct {int e; bit i; logic x;} vec_t;
  vec_t v[$];
  int compared = 0, mismatched = 0, n = 0, en = 0;
  bit armed = 0;
  logic [7:0] b;

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s at t=%0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // expected out after the n-th edge following reset release, from frame arithmetic
  function automatic logic model(int k, int c, int g);
    int l, f, bi;
    logic [7:0] pl;
    if (k == 0) return 1'b1;
    l = (g + 10 + P) * c;
    f = (k - 1) / l;
    bi = ((k - 1) % l) / c;
    pl = 8'(f % 256);
    if (bi < g) return 1'b1;
    if (bi == g) return 1'b0;
    if (bi < g + 9) return pl[bi - g - 1];
    if (P == 1 && bi == g + 9) return ^pl;
    return 1'b1;
  endfunction

  always @(posedge clk) n <= rst ? 0 : n + 1;
  always @(negedge clk) if (armed) begin
    check("model_cpb4", out4, model(n, 4, 2));
    check("model_cpb1", out1, model(n, 1, 1));
  end

  task automatic step();
    @(posedge clk);
    #1;
    en = rst ? 0 : en + 1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (5) begin
      step();
      armed = 1'b1;
    end
    check("reset_out", out4, 1);
    check("reset_out1", out1, 1);
    rst = 1'b0;
  endtask

  task automatic go(input int t);
    while (en < t) step();
  endtask

  task automatic decode(input int base, output logic [7:0] d);
    for (int i = 0; i < 8; i++) begin
      go(base + 12 + 4 * i + 2);
      d[i] = out4;
    end
  endtask

  initial begin
    for (int k = 1; k <= 12; k++)
      v.push_back('{k, 1'b1, (k == 1 || k == 12 || (k == 11 && P == 0)) ? 1'b1 : 1'b0});
`ifdef TEST_PARITY_EN
    v.push_back('{1, 0, 1}); v.push_back('{8, 0, 1}); v.push_back('{9, 0, 0}); v.push_back('{44, 0, 0});
    v.push_back('{45, 0, 0}); v.push_back('{48, 0, 0}); v.push_back('{49, 0, 1}); v.push_back('{60, 0, 1});
    v.push_back('{61, 0, 0}); v.push_back('{64, 0, 0}); v.push_back('{65, 0, 1}); v.push_back('{68, 0, 1});
    v.push_back('{69, 0, 0}); v.push_back('{96, 0, 0}); v.push_back('{97, 0, 1}); v.push_back('{100, 0, 1});
    v.push_back('{101, 0, 1});
`else
    v.push_back('{1, 0, 1}); v.push_back('{8, 0, 1}); v.push_back('{9, 0, 0}); v.push_back('{12, 0, 0});
    v.push_back('{13, 0, 0}); v.push_back('{44, 0, 0}); v.push_back('{45, 0, 1}); v.push_back('{56, 0, 1});
    v.push_back('{57, 0, 0}); v.push_back('{60, 0, 0}); v.push_back('{61, 0, 1}); v.push_back('{64, 0, 1});
    v.push_back('{65, 0, 0}); v.push_back('{92, 0, 0}); v.push_back('{93, 0, 1}); v.push_back('{104, 0, 1});
`endif
    do_reset();
    foreach (v[k]) begin
      if (v[k].e <= en) do_reset();
      go(v[k].e);
      check(v[k].i ? "vec_cpb1" : "vec_cpb4", v[k].i ? out1 : out4, v[k].x);
    end
    do_reset();
    for (int f = 0; f <= 256; f++) begin
      decode(f * L4, b);
      check("wrap_payload", b, 8'(f % 256));
    end
    do_reset();
    go(3 * L4 + 20);
    rst = 1'b1;
    step();
    check("rst_pulse_out", out4, 1);
    rst = 1'b0;
    go(8);
    check("post_rst_gap", out4, 1);
    for (int k = 9; k <= 12; k++) begin
      go(k);
      check("post_rst_start", out4, 0);
    end
    decode(0, b);
    check("post_rst_payload", b, 8'h00);
    for (int k = 0; k < 3000; k++) begin
      rst = ($urandom_range(0, 149) == 0);
      step();
    end
    rst = 1'b0;
    repeat (200) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
